// File: rtl/sample_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sample_sequencer_if : converter soc/eoc handshake plus consumer dav_/rfd port |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
interface sample_sequencer_if;
    logic       soc;
    logic       eocx;
    logic       eocy;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] xo;
    logic [7:0] yo;
    logic       dav_;
    logic       rfd;
    logic [7:0] ovr;

    modport master (
        output soc, xo, yo, dav_, ovr,
        input  eocx, eocy, x, y, rfd
    );

    modport slave (
        input  soc, xo, yo, dav_, ovr,
        output eocx, eocy, x, y, rfd
    );
endinterface
`default_nettype wire

// File: rtl/sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sample_sequencer : periodic soc/eoc sequencer for two ADCs, dav_/rfd output   |
// | Optional overrun counter: SAMPLE_SEQUENCER_OVERRUN_EN.          Rev 1.0      |
// +-----------------------------------------------------------------------------+
module sample_sequencer #(
    parameter int unsigned PERIOD = 32
) (
    input  logic               clock,
    input  logic               reset_,
    sample_sequencer_if.master bus
);

    localparam int unsigned       CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOC   = 3'd1,
        S_CONV  = 3'd2,
        S_LATCH = 3'd3,
        S_OUT   = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soc_q, soc_d;
    logic             dav_n_q, dav_n_d;
    logic [7:0]       xo_q, xo_d;
    logic [7:0]       yo_q, yo_d;
    logic             tick;
    logic             eoc_hi;
    logic             eoc_lo;

    assign tick   = (cnt_q == CNT_LAST);
    assign eoc_hi = bus.eocx & bus.eocy;
    assign eoc_lo = ~bus.eocx & ~bus.eocy;

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (tick && eoc_hi) state_d = S_SOC;
            S_SOC:   if (eoc_lo)         state_d = S_CONV;
            S_CONV:  if (eoc_hi)         state_d = S_LATCH;
            S_LATCH:                     state_d = S_OUT;
            S_OUT:   if (!bus.rfd)       state_d = S_ACK;
            S_ACK:   if (bus.rfd)        state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        soc_d   = (state_d == S_SOC);
        dav_n_d = (state_d != S_OUT);
        xo_d    = xo_q;
        yo_d    = yo_q;
        if (state_q == S_CONV && state_d == S_LATCH) begin
            xo_d = bus.x;
            yo_d = bus.y;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            soc_q   <= 1'b0;
            dav_n_q <= 1'b1;
            xo_q    <= 8'h00;
            yo_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            soc_q   <= soc_d;
            dav_n_q <= dav_n_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
        end
    end

    assign bus.soc  = soc_q;
    assign bus.dav_ = dav_n_q;
    assign bus.xo   = xo_q;
    assign bus.yo   = yo_q;

`ifdef SAMPLE_SEQUENCER_OVERRUN_EN
    logic       missed;
    logic [7:0] ovr_q, ovr_d;

    // A tick is lost when busy, or when idle but a converter is not ready.
    assign missed = tick & ~((state_q == S_IDLE) & eoc_hi);

    always_comb begin
        ovr_d = ovr_q;
        if (missed && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ovr_q <= 8'h00;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.ovr = ovr_q;
`else
    assign bus.ovr = 8'h00;
`endif

endmodule
`default_nettype wire
